// File: rtl/operand_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// operand_fetch : per-beat vector source operand fetch and hand-off, rev 1.0
// ----------------------------------------------------------------------------
module operand_fetch #(
  parameter int VLEN = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        vs1_addr,
  input  logic [4:0]        vs2_addr,
  input  logic [4:0]        vs3_addr,
  input  logic [6:0]        vl,
  input  logic [1:0]        vsew,
  output logic              rd_en,
  output logic [4:0]        rd_addr1,
  output logic [4:0]        rd_addr2,
  output logic [4:0]        rd_addr3,
  input  logic [VLEN-1:0]   rd_data1,
  input  logic [VLEN-1:0]   rd_data2,
  input  logic [VLEN-1:0]   rd_data3,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [VLEN-1:0]   vs1_data,
  output logic [VLEN-1:0]   vs2_data,
  output logic [VLEN-1:0]   vs3_data,
  output logic [1:0]        cycle_count,
  output logic              last,
  output logic [VLEN/8-1:0] valid_bytes,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        vs1_q, vs1_d;
  logic [4:0]        vs2_q, vs2_d;
  logic [4:0]        vs3_q, vs3_d;
  logic [6:0]        vl_q, vl_d;
  logic [1:0]        vsew_q, vsew_d;
  logic [1:0]        beat_q, beat_d;
  logic [VLEN-1:0]   vs1_data_q, vs1_data_d;
  logic [VLEN-1:0]   vs2_data_q, vs2_data_d;
  logic [VLEN-1:0]   vs3_data_q, vs3_data_d;
  logic [1:0]        cc_q, cc_d;
  logic              last_q, last_d;
  logic [VLEN/8-1:0] vb_q, vb_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              w_req_fire;
  logic              w_req_bad;
  logic [4:0]        w_epb_in;
  logic [4:0]        w_epb_q;
  logic [6:0]        w_beat_base;
  logic [6:0]        w_remain;
  logic              w_beat_last;
  logic [4:0]        w_beat_elems;
  logic [4:0]        w_beat_bytes;
  logic [VLEN/8-1:0] w_beat_vb;

  function automatic logic [4:0] epb_of(input logic [1:0] sew);
    case (sew)
      2'b00:   epb_of = 5'd16;
      2'b01:   epb_of = 5'd8;
      default: epb_of = 5'd4;
    endcase
  endfunction

  assign w_epb_in   = epb_of(vsew);
  assign w_epb_q    = epb_of(vsew_q);
  assign w_req_fire = req_valid && req_ready;
  // A group spans at most four registers, so vl may not exceed 4*epb.
  assign w_req_bad  = (vsew == 2'b11) || (vl > {w_epb_in, 2'b00});

  // Elements still outstanding at the current beat; the beat is last when
  // they fit in a single register.
  assign w_beat_base  = {5'd0, beat_q} * {2'd0, w_epb_q};
  assign w_remain     = vl_q - w_beat_base;
  assign w_beat_last  = (w_remain <= {2'd0, w_epb_q});
  assign w_beat_elems = w_beat_last ? w_remain[4:0] : w_epb_q;
  assign w_beat_bytes = w_beat_elems << vsew_q;

  always_comb begin
    w_beat_vb = '0;
    for (int i = 0; i < VLEN/8; i++) begin
      w_beat_vb[i] = (5'(i) < w_beat_bytes);
    end
  end

  always_comb begin
    state_d    = state_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    vs3_d      = vs3_q;
    vl_d       = vl_q;
    vsew_d     = vsew_q;
    beat_d     = beat_q;
    vs1_data_d = vs1_data_q;
    vs2_data_d = vs2_data_q;
    vs3_data_d = vs3_data_q;
    cc_d       = cc_q;
    last_d     = last_q;
    vb_d       = vb_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req_fire) begin
          vs1_d  = vs1_addr;
          vs2_d  = vs2_addr;
          vs3_d  = vs3_addr;
          vl_d   = vl;
          vsew_d = vsew;
          beat_d = 2'd0;
          if (w_req_bad) begin
            err_d = 1'b1;
          end else if (vl == 7'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = LOAD;
      end
      LOAD: begin
        vs1_data_d = rd_data1;
        vs2_data_d = rd_data2;
        vs3_data_d = rd_data3;
        cc_d       = beat_q;
        last_d     = w_beat_last;
        vb_d       = w_beat_vb;
        state_d    = HOLD;
      end
      HOLD: begin
        if (op_ready) begin
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = READ;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vs3_q      <= '0;
      vl_q       <= '0;
      vsew_q     <= '0;
      beat_q     <= '0;
      vs1_data_q <= '0;
      vs2_data_q <= '0;
      vs3_data_q <= '0;
      cc_q       <= '0;
      last_q     <= 1'b0;
      vb_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      vs3_q      <= vs3_d;
      vl_q       <= vl_d;
      vsew_q     <= vsew_d;
      beat_q     <= beat_d;
      vs1_data_q <= vs1_data_d;
      vs2_data_q <= vs2_data_d;
      vs3_data_q <= vs3_data_d;
      cc_q       <= cc_d;
      last_q     <= last_d;
      vb_q       <= vb_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE) && !reset;
  assign rd_en       = (state_q == READ);
  assign op_valid    = (state_q == HOLD);
  // Register index wraps modulo 32 across the group.
  assign rd_addr1    = vs1_q + {3'd0, beat_q};
  assign rd_addr2    = vs2_q + {3'd0, beat_q};
  assign rd_addr3    = vs3_q + {3'd0, beat_q};
  assign vs1_data    = vs1_data_q;
  assign vs2_data    = vs2_data_q;
  assign vs3_data    = vs3_data_q;
  assign cycle_count = cc_q;
  assign last        = last_q;
  assign valid_bytes = vb_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
`default_nettype wire
